// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw input pins and conditioned outputs of the input front-end
interface input_conditioner_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] ui_in;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_rise;
  logic [WIDTH-1:0] btn_fall;
  logic             pause_pulse;
  logic             resume_pulse;
  logic [2:0]       speed;
  modport master (output ui_in, input btn_level, btn_rise, btn_fall, pause_pulse, resume_pulse, speed);
  modport slave  (input ui_in, output btn_level, btn_rise, btn_fall, pause_pulse, resume_pulse, speed);
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise, debounce and edge-detect ui_in; derive pause/resume strobes and speed
module input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  input_conditioner_if.slave io
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][CW-1:0]          cnt;
  logic [WIDTH-1:0]                  sync, level, rise, fall, flip;
  logic                              pause, resume;
  logic [2:0]                        speed;
  assign sync = sync_q[SYNC_STAGES-1];
  for (genvar i = 0; i < WIDTH; i++) begin : g_flip
    assign flip[i] = (sync[i] != level[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= '0;
      rise   <= '0;
      fall   <= '0;
      pause  <= 1'b0;
      resume <= 1'b0;
      speed  <= 3'd1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io.ui_in};
      for (int i = 0; i < WIDTH; i++) cnt[i] <= (sync[i] == level[i] || flip[i]) ? '0 : cnt[i] + CW'(1);
      level  <= level ^ flip;
      rise   <= flip & ~level;
      fall   <= flip & level;
      pause  <= flip[0] & ~level[0];
      // pause wins when both strobes would fire together
      resume <= flip[1] & ~level[1] & ~(flip[0] & ~level[0]);
      speed  <= level[7] ? 3'd6 : level[6] ? 3'd5 : level[5] ? 3'd4 :
                level[4] ? 3'd3 : level[3] ? 3'd2 : 3'd1;
    end
  end
  assign io.btn_level    = level;
  assign io.btn_rise     = rise;
  assign io.btn_fall     = fall;
  assign io.pause_pulse  = pause;
  assign io.resume_pulse = resume;
  assign io.speed        = speed;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus, per-cycle comparison against a sample-window model
module tb_input_conditioner;
  localparam int S = 2, D = 4, H = S + D - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, failures = 0;
  input_conditioner_if io ();
  input_conditioner #(.WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;

  // Model: hist[k] holds ui_in as sampled k+1 edges ago; a bit flips once its last D synced samples all differ from the level.
  logic [7:0] hist [H];
  logic [7:0] m_lvl = '0, m_rise = '0, m_fall = '0, m_flip;
  logic       m_pause = 1'b0, m_resume = 1'b0;
  logic [2:0] m_speed = 3'd1;

  function automatic logic [2:0] speed_of(input logic [7:0] l);
    logic [2:0] s = 3'd1;
    for (int b = 3; b < 8; b++) if (l[b]) s = 3'(b - 1);
    return s;
  endfunction

  initial begin
    for (int k = 0; k < H; k++) hist[k] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < H; k++) hist[k] = '0;
        {m_lvl, m_rise, m_fall, m_pause, m_resume} = '0;
        m_speed = 3'd1;
      end else begin
        m_flip = 8'hFF;
        for (int k = S - 1; k < H; k++) m_flip &= hist[k] ^ m_lvl;
        m_speed  = speed_of(m_lvl);
        m_rise   = m_flip & ~m_lvl;
        m_fall   = m_flip & m_lvl;
        m_pause  = m_rise[0];
        m_resume = m_rise[1] & ~m_rise[0];
        m_lvl    = m_lvl ^ m_flip;
        for (int k = H - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = io.ui_in;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({io.btn_level, io.btn_rise, io.btn_fall, io.pause_pulse, io.resume_pulse, io.speed} !==
        {m_lvl, m_rise, m_fall, m_pause, m_resume, m_speed}) begin
      failures++;
      $display("FAIL model t=%0t got lvl=%h rise=%h fall=%h p=%b r=%b spd=%0d expected lvl=%h rise=%h fall=%h p=%b r=%b spd=%0d",
               $time, io.btn_level, io.btn_rise, io.btn_fall, io.pause_pulse, io.resume_pulse, io.speed,
               m_lvl, m_rise, m_fall, m_pause, m_resume, m_speed);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic seen;

  initial begin
    io.ui_in = 8'hFF;
    tick(4);
    check("rst_level", io.btn_level, 0);
    check("rst_rise", io.btn_rise, 0);
    check("rst_speed", io.speed, 1);
    rst_n = 1'b1;
    tick(5);
    check("release_rise", io.btn_rise, 0);
    check("release_level", io.btn_level, 0);
    tick(1);
    check("release_level6", io.btn_level, 8'hFF);
    tick(1);
    check("release_speed7", io.speed, 6);
    io.ui_in = 8'h00;
    tick(8);
    check("idle_level", io.btn_level, 0);
    io.ui_in = 8'h01;
    tick(5);
    check("pause_lvl5", io.btn_level, 0);
    tick(1);
    check("pause_lvl6", io.btn_level, 8'h01);
    check("pause_pulse6", io.pause_pulse, 1);
    tick(1);
    check("pause_pulse7", io.pause_pulse, 0);
    check("pause_speed", io.speed, 1);
    io.ui_in = 8'h00;
    tick(8);
    io.ui_in = 8'h08;
    tick(3);
    io.ui_in = 8'h00;
    seen = 1'b0;
    repeat (8) begin
      tick(1);
      seen |= io.btn_rise[3];
    end
    check("glitch_rise", seen, 0);
    check("glitch_level", io.btn_level, 0);
    check("glitch_speed", io.speed, 1);
    io.ui_in = 8'h90;
    tick(6);
    check("speed6_e6", io.speed, 1);
    tick(1);
    check("speed6_e7", io.speed, 6);
    io.ui_in = 8'h10;
    tick(5);
    check("fall7_e5", io.btn_fall, 0);
    tick(1);
    check("fall7_e6", io.btn_fall, 8'h80);
    check("speed_hold_e6", io.speed, 6);
    tick(1);
    check("speed3_e7", io.speed, 3);
    check("fall7_e7", io.btn_fall, 0);
    io.ui_in = 8'h13;
    tick(6);
    check("both_rise", io.btn_rise, 8'h03);
    check("both_pause", io.pause_pulse, 1);
    check("both_resume", io.resume_pulse, 0);
    tick(1);
    check("both_rise_end", io.btn_rise, 0);
    io.ui_in = 8'h00;
    tick(8);
    io.ui_in = 8'h02;
    tick(6);
    check("resume_pulse", io.resume_pulse, 1);
    check("resume_nopause", io.pause_pulse, 0);
    tick(1);
    check("resume_end", io.resume_pulse, 0);
    io.ui_in = 8'h00;
    tick(8);
    io.ui_in = 8'h20;
    tick(5);
    rst_n = 1'b0;
    #1;
    check("midreset_level", io.btn_level, 0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check("fresh_e5", io.btn_level, 0);
    tick(1);
    check("fresh_e6", io.btn_level, 8'h20);
    check("fresh_rise", io.btn_rise, 8'h20);
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
